// File: rtl/uart_rx_cfg.sv
// UART receiver with configurable oversampling, 5-9 data bits, optional parity and 1/2 stop bits.
// Each bit is a 3-sample majority vote around mid-bit; words leave over a valid/ready handshake.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_S0   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] C_S1   = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] C_DEC  = CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    IDX_DLAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    IDX_SLAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t               state_q;
    logic                 sync1_q, rx_s_q;
    logic [CW-1:0]        cnt_q;
    logic [3:0]           idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 smp0_q, smp1_q;
    logic                 perr_q, ferr_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q, parity_err_q, frame_err_q, break_det_q, overrun_q;

    logic maj, decide, last_tick, par_x, par_bad, done, ferr_fin, hs;

    // Third sample is the live rx_s value in the decision cycle itself.
    assign maj       = (smp0_q & smp1_q) | (smp0_q & rx_s_q) | (smp1_q & rx_s_q);
    assign decide    = (cnt_q == C_DEC);
    assign last_tick = (cnt_q == C_LAST);
    assign par_x     = (^shift_q) ^ maj;
    assign par_bad   = (PARITY == 1) ? ~par_x : par_x;
    assign done      = (state_q == S_STOP) && decide && (idx_q == IDX_SLAST);
    assign ferr_fin  = ferr_q | ~maj;
    assign hs        = rx_valid_q & rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            smp0_q       <= 1'b1;
            smp1_q       <= 1'b1;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_det_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync1_q <= rx_in;
            rx_s_q  <= sync1_q;
            if (cnt_q == C_S0) smp0_q <= rx_s_q;
            if (cnt_q == C_S1) smp1_q <= rx_s_q;
            cnt_q <= last_tick ? '0 : cnt_q + CW'(1);

            case (state_q)
                // The cycle that sees the falling edge counts as cnt 0 of the start bit.
                S_IDLE: begin
                    cnt_q  <= CW'(1);
                    idx_q  <= '0;
                    perr_q <= 1'b0;
                    ferr_q <= 1'b0;
                    if (!rx_s_q) state_q <= S_START;
                end
                S_START: begin
                    if (decide && maj)  state_q <= S_IDLE;
                    else if (last_tick) state_q <= S_DATA;
                end
                S_DATA: begin
                    if (decide) shift_q <= {maj, shift_q[DATA_BITS-1:1]};
                    if (last_tick) begin
                        if (idx_q == IDX_DLAST) begin
                            idx_q   <= '0;
                            state_q <= (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                S_PAR: begin
                    if (decide)    perr_q  <= par_bad;
                    if (last_tick) state_q <= S_STOP;
                end
                S_STOP: begin
                    if (decide) begin
                        ferr_q <= ferr_fin;
                        if (done) state_q <= S_IDLE;
                    end
                    if (last_tick) idx_q <= idx_q + 4'd1;
                end
                default: state_q <= S_IDLE;
            endcase

            // A finished frame replaces the held word only if the slot is free or emptying now.
            if (done) begin
                if (!rx_valid_q || rx_ready) begin
                    rx_data_q    <= shift_q;
                    parity_err_q <= (PARITY != 0) && perr_q;
                    frame_err_q  <= ferr_fin;
                    break_det_q  <= ferr_fin && (shift_q == '0);
                    rx_valid_q   <= 1'b1;
                end
            end else if (hs) begin
                rx_valid_q <= 1'b0;
            end

            if (done && rx_valid_q && !rx_ready) overrun_q <= 1'b1;
            else if (hs)                         overrun_q <= 1'b0;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign break_det  = break_det_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three builds (8N1, 8E1, 9O2) driven from one scoreboard-based sequence.
module tb_uart_rx_cfg;

    localparam int CPB = 16;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rxl [3] = '{1'b1, 1'b1, 1'b1};
    logic rdy [3] = '{1'b1, 1'b1, 1'b1};
    logic vld [3];
    logic pe  [3];
    logic fe  [3];
    logic bk  [3];
    logic ovr [3];
    logic bsy [3];
    logic [7:0] d0, d1;
    logic [8:0] d2;
    logic [8:0] dat [3];

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    int   hs_cnt [3] = '{0, 0, 0};
    int   rise   [3] = '{0, 0, 0};
    logic vprev  [3] = '{1'b0, 1'b0, 1'b0};
    logic [11:0] cap [3] = '{12'h0, 12'h0, 12'h0};
    exp_t sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        dat[0] = {1'b0, d0};
        dat[1] = {1'b0, d1};
        dat[2] = d2;
    end

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_def (
        .clk(clk), .rst_n(rst_n), .rx_in(rxl[0]), .rx_data(d0), .rx_valid(vld[0]),
        .rx_ready(rdy[0]), .parity_err(pe[0]), .frame_err(fe[0]), .break_det(bk[0]),
        .overrun(ovr[0]), .busy(bsy[0]));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_par (
        .clk(clk), .rst_n(rst_n), .rx_in(rxl[1]), .rx_data(d1), .rx_valid(vld[1]),
        .rx_ready(rdy[1]), .parity_err(pe[1]), .frame_err(fe[1]), .break_det(bk[1]),
        .overrun(ovr[1]), .busy(bsy[1]));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY(1), .STOP_BITS(2)) u_cfg (
        .clk(clk), .rst_n(rst_n), .rx_in(rxl[2]), .rx_data(d2), .rx_valid(vld[2]),
        .rx_ready(rdy[2]), .parity_err(pe[2]), .frame_err(fe[2]), .break_det(bk[2]),
        .overrun(ovr[2]), .busy(bsy[2]));

    // Output monitor: records first-valid cycle and the word taken at each handshake.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (vld[i] && !vprev[i]) rise[i] <= cyc;
            vprev[i] <= vld[i];
            if (vld[i] && rdy[i]) begin
                hs_cnt[i] <= hs_cnt[i] + 1;
                cap[i]    <= {dat[i], pe[i], fe[i], bk[i]};
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mkframe(input logic [8:0] d, input int nd, input int np, input logic pb,
                           input logic sv, input int ns, output logic [15:0] f, output int n);
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < nd; i++) f[1+i] = d[i];
        n = 1 + nd;
        if (np != 0) begin
            f[n] = pb;
            n++;
        end
        for (int i = 0; i < ns; i++) begin
            f[n] = sv;
            n++;
        end
    endtask

    task automatic send(input int sel, input logic [15:0] f, input int n, output int c0);
        tick();
        c0 = cyc;
        for (int i = 0; i < n; i++) begin
            rxl[sel] = f[i];
            repeat (CPB) tick();
        end
        rxl[sel] = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total++; if (vld[i] !== 1'b0) begin bad++; $display("FAIL reset_valid[%0d]: got %b want 0", i, vld[i]); end
            total++; if (dat[i] !== 9'h0) begin bad++; $display("FAIL reset_data[%0d]: got %h want 0", i, dat[i]); end
            total++; if (pe[i] !== 1'b0) begin bad++; $display("FAIL reset_perr[%0d]: got %b want 0", i, pe[i]); end
            total++; if (fe[i] !== 1'b0) begin bad++; $display("FAIL reset_ferr[%0d]: got %b want 0", i, fe[i]); end
            total++; if (bk[i] !== 1'b0) begin bad++; $display("FAIL reset_break[%0d]: got %b want 0", i, bk[i]); end
            total++; if (ovr[i] !== 1'b0) begin bad++; $display("FAIL reset_overrun[%0d]: got %b want 0", i, ovr[i]); end
            total++; if (bsy[i] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d]: got %b want 0", i, bsy[i]); end
        end
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_basic();
        logic [15:0] f;
        int n, c0, h0;
        exp_t e;
        mkframe(9'h0A5, 8, 0, 1'b0, 1'b1, 1, f, n);
        sb.push_back('{9'h0A5, 1'b0, 1'b0, 1'b0});
        h0 = hs_cnt[0];
        send(0, f, n, c0);
        for (int i = 0; i < 200 && hs_cnt[0] == h0; i++) @(negedge clk);
        e = sb.pop_front();
        total++; if (cap[0] !== e) begin bad++; $display("FAIL basic_word: got %h want %h", cap[0], e); end
        total++; if (rise[0] - c0 != 156) begin bad++; $display("FAIL basic_latency: got %0d want 156", rise[0] - c0); end
        repeat (4) @(negedge clk);
        total++; if (hs_cnt[0] - h0 != 1) begin bad++; $display("FAIL basic_pulse: got %0d want 1", hs_cnt[0] - h0); end
        total++; if (vld[0] !== 1'b0) begin bad++; $display("FAIL basic_valid_drop: got %b want 0", vld[0]); end
    endtask

    task automatic test_glitch();
        int c0, h0;
        h0 = hs_cnt[0];
        tick();
        c0 = cyc;
        rxl[0] = 1'b0;
        repeat (4) tick();
        rxl[0] = 1'b1;
        while (cyc < c0 + 5) @(negedge clk);
        total++; if (bsy[0] !== 1'b1) begin bad++; $display("FAIL glitch_busy_high: got %b want 1", bsy[0]); end
        while (cyc < c0 + 15) @(negedge clk);
        total++; if (bsy[0] !== 1'b0) begin bad++; $display("FAIL glitch_busy_low: got %b want 0", bsy[0]); end
        repeat (30) @(negedge clk);
        total++; if (hs_cnt[0] != h0 || vld[0] !== 1'b0) begin bad++; $display("FAIL glitch_no_output: got hs=%0d vld=%b want hs=%0d vld=0", hs_cnt[0], vld[0], h0); end
        total++; if ({pe[0], fe[0], bk[0], ovr[0]} !== 4'b0) begin bad++; $display("FAIL glitch_flags: got %b want 0000", {pe[0], fe[0], bk[0], ovr[0]}); end
    endtask

    task automatic test_parity();
        logic [15:0] f;
        int n, c0, h0;
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            mkframe(9'h007, 8, 1, k[0], 1'b1, 1, f, n);
            sb.push_back('{9'h007, ~k[0], 1'b0, 1'b0});
            h0 = hs_cnt[1];
            send(1, f, n, c0);
            for (int i = 0; i < 200 && hs_cnt[1] == h0; i++) @(negedge clk);
            e = sb.pop_front();
            total++; if (cap[1] !== e) begin bad++; $display("FAIL parity_word%0d: got %h want %h", k, cap[1], e); end
            total++; if (rise[1] - c0 != 172) begin bad++; $display("FAIL parity_latency%0d: got %0d want 172", k, rise[1] - c0); end
            repeat (10) tick();
        end
    endtask

    task automatic test_frame_err();
        logic [15:0] f;
        int n, c0, h0, hbase;
        exp_t e;
        hbase = hs_cnt[0];
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                mkframe(9'h000, 8, 0, 1'b0, 1'b0, 1, f, n);
                sb.push_back('{9'h000, 1'b0, 1'b1, 1'b1});
            end else begin
                mkframe(9'h055, 8, 0, 1'b0, 1'b1, 1, f, n);
                sb.push_back('{9'h055, 1'b0, 1'b0, 1'b0});
            end
            h0 = hs_cnt[0];
            send(0, f, n, c0);
            for (int i = 0; i < 200 && hs_cnt[0] == h0; i++) @(negedge clk);
            e = sb.pop_front();
            total++; if (cap[0] !== e) begin bad++; $display("FAIL frame_word%0d: got %h want %h", k, cap[0], e); end
            repeat (40) tick();
        end
        total++; if (hs_cnt[0] - hbase != 2) begin bad++; $display("FAIL frame_count: got %0d want 2", hs_cnt[0] - hbase); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] f;
        int n, c0;
        exp_t e;
        rdy[0] = 1'b0;
        mkframe(9'h011, 8, 0, 1'b0, 1'b1, 1, f, n);
        sb.push_back('{9'h011, 1'b0, 1'b0, 1'b0});
        send(0, f, n, c0);
        @(negedge clk);
        total++; if (vld[0] !== 1'b1 || ovr[0] !== 1'b0) begin bad++; $display("FAIL b2b_first: got vld=%b ovr=%b want vld=1 ovr=0", vld[0], ovr[0]); end
        mkframe(9'h022, 8, 0, 1'b0, 1'b1, 1, f, n);
        send(0, f, n, c0);
        repeat (20) @(negedge clk);
        total++; if (vld[0] !== 1'b1) begin bad++; $display("FAIL b2b_held_valid: got %b want 1", vld[0]); end
        total++; if (dat[0] !== sb[0].d) begin bad++; $display("FAIL b2b_held_data: got %h want %h", dat[0], sb[0].d); end
        total++; if (ovr[0] !== 1'b1) begin bad++; $display("FAIL b2b_overrun_set: got %b want 1", ovr[0]); end
        tick();
        rdy[0] = 1'b1;
        tick();
        rdy[0] = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        total++; if (cap[0] !== e) begin bad++; $display("FAIL b2b_word: got %h want %h", cap[0], e); end
        total++; if (vld[0] !== 1'b0) begin bad++; $display("FAIL b2b_valid_clear: got %b want 0", vld[0]); end
        total++; if (ovr[0] !== 1'b0) begin bad++; $display("FAIL b2b_overrun_clear: got %b want 0", ovr[0]); end
        rdy[0] = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_cfg_reset();
        logic [15:0] f;
        int n, c0, h0;
        exp_t e;
        mkframe(9'h13C, 9, 1, 1'b0, 1'b1, 2, f, n);
        h0 = hs_cnt[2];
        send(2, f, 4, c0);
        rxl[2] = f[4];
        repeat (8) tick();
        @(negedge clk);
        total++; if (bsy[2] !== 1'b1) begin bad++; $display("FAIL cfg_busy_midframe: got %b want 1", bsy[2]); end
        tick();
        rst_n  = 1'b0;
        rxl[2] = 1'b1;
        repeat (2) @(negedge clk);
        total++; if ({vld[2], pe[2], fe[2], bk[2], ovr[2], bsy[2]} !== 6'b0) begin bad++; $display("FAIL cfg_reset_flags: got %b want 000000", {vld[2], pe[2], fe[2], bk[2], ovr[2], bsy[2]}); end
        total++; if (dat[2] !== 9'h0) begin bad++; $display("FAIL cfg_reset_data: got %h want 0", dat[2]); end
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        total++; if (bsy[2] !== 1'b0 || vld[2] !== 1'b0 || hs_cnt[2] != h0) begin bad++; $display("FAIL cfg_no_partial: got busy=%b vld=%b hs=%0d want 0 0 %0d", bsy[2], vld[2], hs_cnt[2], h0); end
        sb.push_back('{9'h13C, 1'b0, 1'b0, 1'b0});
        send(2, f, n, c0);
        for (int i = 0; i < 200 && hs_cnt[2] == h0; i++) @(negedge clk);
        e = sb.pop_front();
        total++; if (cap[2] !== e) begin bad++; $display("FAIL cfg_word: got %h want %h", cap[2], e); end
        total++; if (rise[2] - c0 != 204) begin bad++; $display("FAIL cfg_latency: got %0d want 204", rise[2] - c0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_parity();
        test_frame_err();
        test_back_to_back();
        test_cfg_reset();
        repeat (5) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
